// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity modes, FSM state
// encoding and the clocks-per-bit helper.
package uart_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StStart   = 3'd1,
        StData    = 3'd2,
        StParity  = 3'd3,
        StStop    = 3'd4,
        StBrkWait = 3'd5
    } rx_state_e;

    function automatic int unsigned calc_cpb(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop synchroniser on the raw RX line plus a 3-sample majority voter.
// bit_val is valid in the cycle where cnt == mid + 1 (third sample is the live rxs).
module uart_rx_sampler #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_i,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] mid,
    output logic             rxs,
    output logic             bit_val
);

    logic sync1;
    logic samp_a;
    logic samp_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= 1'b1;
            rxs    <= 1'b1;
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            sync1 <= rx_i;
            rxs   <= sync1;
            if (cnt == mid - CNT_W'(1)) samp_a <= rxs;
            if (cnt == mid)             samp_b <= rxs;
        end
    end

    assign bit_val = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS 5..9, none/odd/even parity, 1 or 2 stop bits,
// with false-start rejection, parity/framing error flags and break detection.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PARITY_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 data_valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int unsigned CPB   = calc_cpb(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = $clog2(CPB);
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] MID      = CNT_W'(CPB / 2);
    localparam logic [CNT_W-1:0] MID_P1   = CNT_W'(CPB / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 stop_idx;
    logic                 par_bit;
    logic                 par_bad;
    logic                 stop_low;
    logic                 stop0_low;

    logic rxs;
    logic bit_val;
    logic at_vote;
    logic bit_end;
    logic exp_par;
    logic stop_last;
    logic first_stop_low;
    logic is_break;

    uart_rx_sampler #(
        .CNT_W (CNT_W)
    ) u_sampler (
        .clk     (clk),
        .rst     (rst),
        .rx_i    (rx_i),
        .cnt     (cnt),
        .mid     (MID),
        .rxs     (rxs),
        .bit_val (bit_val)
    );

    assign at_vote   = (cnt == MID_P1);
    assign bit_end   = (cnt == CNT_LAST);
    assign exp_par   = (PARITY == PARITY_ODD) ? ~(^shreg) : ^shreg;
    assign stop_last = (STOP_BITS == 1) ? 1'b1 : stop_idx;

    // With two stop bits the first one was voted earlier; otherwise it is the live vote.
    assign first_stop_low = stop_idx ? stop0_low : ~bit_val;
    assign is_break       = (shreg == '0) && !par_bit && first_stop_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= StIdle;
            cnt          <= '0;
            idx          <= '0;
            shreg        <= '0;
            stop_idx     <= 1'b0;
            par_bit      <= 1'b0;
            par_bad      <= 1'b0;
            stop_low     <= 1'b0;
            stop0_low    <= 1'b0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            break_o      <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            break_o      <= 1'b0;
            cnt          <= bit_end ? '0 : cnt + CNT_W'(1);

            unique case (state)
                StIdle: begin
                    cnt <= '0;
                    // The detection cycle counts as cnt = 0 of the start bit.
                    if (!rxs) begin
                        state  <= StStart;
                        cnt    <= CNT_W'(1);
                        busy_o <= 1'b1;
                    end
                end

                StStart: begin
                    if (at_vote && bit_val) begin
                        state  <= StIdle;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end else if (bit_end) begin
                        state     <= StData;
                        idx       <= '0;
                        shreg     <= '0;
                        stop_idx  <= 1'b0;
                        par_bit   <= 1'b0;
                        par_bad   <= 1'b0;
                        stop_low  <= 1'b0;
                        stop0_low <= 1'b0;
                    end
                end

                StData: begin
                    if (at_vote) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_LAST) begin
                            state <= (PARITY != PARITY_NONE) ? StParity : StStop;
                        end
                    end
                end

                StParity: begin
                    if (at_vote) begin
                        par_bit <= bit_val;
                        par_bad <= (bit_val != exp_par);
                    end
                    if (bit_end) state <= StStop;
                end

                StStop: begin
                    if (at_vote) begin
                        if (!stop_idx) stop0_low <= ~bit_val;
                        if (!bit_val)  stop_low  <= 1'b1;
                        if (stop_last) begin
                            data_o       <= shreg;
                            data_valid_o <= 1'b1;
                            parity_err_o <= par_bad;
                            frame_err_o  <= stop_low | ~bit_val;
                            if (is_break) begin
                                break_o <= 1'b1;
                                state   <= StBrkWait;
                            end else begin
                                // Leave early so a start edge late in the stop bit is caught.
                                state  <= StIdle;
                                cnt    <= '0;
                                busy_o <= 1'b0;
                            end
                        end
                    end else if (bit_end) begin
                        stop_idx <= 1'b1;
                    end
                end

                StBrkWait: begin
                    if (rxs) begin
                        state  <= StIdle;
                        cnt    <= '0;
                        busy_o <= 1'b0;
                    end
                end

                default: begin
                    state  <= StIdle;
                    cnt    <= '0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
